// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix geometry, scan-result encoding, keymap names.
package keypad_pkg;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int KEY_CODE_W = 4;
  localparam int ROW_W      = $clog2(NUM_ROWS);
  localparam int COL_W      = $clog2(NUM_COLS);

  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_KEY   = 2'd1;
  localparam logic [1:0] RES_MULTI = 2'd2;

  // Board keymap; code 0 (row 0 / col 0) is left unused because the core treats note 0 as silence.
  localparam logic [KEY_CODE_W-1:0] KEY_UNUSED = 4'd0;
  localparam logic [KEY_CODE_W-1:0] KEY_1 = 4'd1,  KEY_2 = 4'd2,  KEY_3 = 4'd3,  KEY_4 = 4'd4;
  localparam logic [KEY_CODE_W-1:0] KEY_5 = 4'd5,  KEY_6 = 4'd6,  KEY_7 = 4'd7,  KEY_8 = 4'd8;
  localparam logic [KEY_CODE_W-1:0] KEY_9 = 4'd9,  KEY_A = 4'd10, KEY_B = 4'd11, KEY_C = 4'd12;
  localparam logic [KEY_CODE_W-1:0] KEY_D = 4'd13, KEY_E = 4'd14, KEY_F = 4'd15;

  function automatic logic [KEY_CODE_W-1:0] key_code_of(input logic [ROW_W-1:0] row,
                                                        input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-scan debounce: a result must repeat DEBOUNCE_SCANS times before the key outputs follow it.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_valid,
  input  logic [1:0]            scan_res,
  input  logic [KEY_CODE_W-1:0] scan_code,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_press,
  output logic                  key_release
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS);

  logic [3:0]            stable_cnt;
  logic [3:0]            cnt_next;
  logic [1:0]            last_res;
  logic [KEY_CODE_W-1:0] last_code;
  logic                  same;
  logic                  reached;

  always_comb begin
    same = (scan_res == last_res) && ((scan_res != RES_KEY) || (scan_code == last_code));
    if (!same)
      cnt_next = 4'd1;
    else if (stable_cnt == CNT_MAX)
      cnt_next = CNT_MAX;
    else
      cnt_next = stable_cnt + 4'd1;
    // Act only on the scan that first reaches the threshold, not while it stays saturated.
    reached = (cnt_next == CNT_MAX) && !(same && (stable_cnt == CNT_MAX));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_cnt  <= '0;
      last_res    <= RES_NONE;
      last_code   <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (scan_valid) begin
        stable_cnt <= cnt_next;
        last_res   <= scan_res;
        last_code  <= scan_code;
        if (reached) begin
          case (scan_res)
            RES_KEY: begin
              key_code  <= scan_code;
              key_valid <= 1'b1;
              key_press <= !key_valid || (key_code != scan_code);
            end
            RES_NONE: begin
              if (key_valid) begin
                key_valid   <= 1'b0;
                key_release <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row drive, column synchroniser, per-scan result, debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 2500,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_COLS-1:0]   col_n,
  output logic [NUM_ROWS-1:0]   row_n,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_press,
  output logic                  key_release
);

  localparam int                SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_ROWS - 1);

  logic [SLOT_W-1:0]     slot_cnt;
  logic [ROW_W-1:0]      row_idx;
  logic [NUM_COLS-1:0]   col_s1;
  logic [NUM_COLS-1:0]   col_s2;
  logic                  acc_found;
  logic                  acc_multi;
  logic [KEY_CODE_W-1:0] acc_code;
  logic                  scan_valid;
  logic [1:0]            scan_res;
  logic [KEY_CODE_W-1:0] scan_code;

  logic [NUM_COLS-1:0]   col_low;
  logic                  row_hit;
  logic                  row_multi;
  logic [COL_W-1:0]      row_col;
  logic                  new_found;
  logic                  new_multi;
  logic [KEY_CODE_W-1:0] new_code;

  always_comb begin
    row_n = ~(NUM_ROWS'(1) << row_idx);
  end

  // Decode the current row's synchronised columns and fold it into the running scan.
  always_comb begin
    col_low   = ~col_s2;
    row_hit   = (col_low != '0);
    row_multi = ((col_low & (col_low - NUM_COLS'(1))) != '0);
    row_col   = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (col_low[c]) row_col = COL_W'(c);
    end
    new_multi = acc_multi || row_multi || (acc_found && row_hit);
    new_found = acc_found || row_hit;
    new_code  = (row_hit && !acc_found) ? key_code_of(row_idx, row_col) : acc_code;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt   <= '0;
      row_idx    <= '0;
      acc_found  <= 1'b0;
      acc_multi  <= 1'b0;
      acc_code   <= '0;
      scan_valid <= 1'b0;
      scan_res   <= RES_NONE;
      scan_code  <= '0;
    end else begin
      scan_valid <= 1'b0;
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        row_idx  <= row_idx + ROW_W'(1);
        if (row_idx == ROW_LAST) begin
          scan_valid <= 1'b1;
          scan_res   <= new_multi ? RES_MULTI : (new_found ? RES_KEY : RES_NONE);
          scan_code  <= new_code;
          acc_found  <= 1'b0;
          acc_multi  <= 1'b0;
          acc_code   <= '0;
        end else begin
          acc_found <= new_found;
          acc_multi <= new_multi;
          acc_code  <= new_code;
        end
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .scan_valid (scan_valid),
    .scan_res   (scan_res),
    .scan_code  (scan_code),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_press  (key_press),
    .key_release(key_release)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner; models the key matrix from row_n and checks debounced outputs.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_press;
  logic        key_release;
  logic [15:0] keys;

  int checks;
  int errors;
  int press_cnt;
  int release_cnt;
  int both_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .col_n      (col_n),
    .row_n      (row_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_press  (key_press),
    .key_release(key_release)
  );

  // A held key (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_press) press_cnt++;
    if (key_release) release_cnt++;
    if (key_press && key_release) both_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input logic level, input int limit, output int cyc);
    cyc = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (key_valid === level) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc, p0, r0, act, low, prev, found;
    checks = 0; errors = 0; press_cnt = 0; release_cnt = 0; both_cnt = 0;
    keys  = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_row_n", row_n, 4'b1110);
    check("rst_key_code", key_code, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_press", key_press, 0);
    check("rst_key_release", key_release, 0);

    // 1: idle scanning
    reset = 1'b1;
    act = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k <= 32) check("t1_row_n", row_n, 4'hF & ~(1 << ((k / 4) % 4)));
      act += int'(key_valid) + int'(key_press) + int'(key_release);
    end
    check("t1_idle_activity", act, 0);

    // 2: clean press/release of row2/col1
    p0 = press_cnt; r0 = release_cnt;
    keys[9] = 1'b1;
    wait_valid(1'b1, 51, cyc);
    check("t2_press_in_time", int'(cyc <= 51), 1);
    check("t2_key_code", key_code, 9);
    repeat (40) @(negedge clk);
    check("t2_press_pulses", press_cnt - p0, 1);
    check("t2_no_release", release_cnt - r0, 0);
    keys = '0;
    wait_valid(1'b0, 51, cyc);
    check("t2_release_in_time", int'(cyc <= 51), 1);
    check("t2_code_held", key_code, 9);
    repeat (20) @(negedge clk);
    check("t2_release_pulses", release_cnt - r0, 1);
    check("t2_press_total", press_cnt - p0, 1);

    // 3: row1/col3 bouncing, phase-locked to the start of the row-1 slot
    found = 0; prev = row_n;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (row_n == 4'b1101 && prev != 4'b1101) begin
        found = 1;
        break;
      end
      prev = row_n;
    end
    check("t3_row1_found", found, 1);
    p0 = press_cnt;
    act = 0;
    for (int t = 0; t < 60; t++) begin
      if (t > 0) @(negedge clk);
      keys[7] = ((t / 5) % 2 == 0);
      act += int'(key_valid) + int'(key_press) + int'(key_release);
    end
    @(negedge clk);
    keys[7] = 1'b1;
    check("t3_bounce_quiet", act, 0);
    wait_valid(1'b1, 51, cyc);
    check("t3_press_in_time", int'(cyc <= 51), 1);
    check("t3_key_code", key_code, 7);
    repeat (30) @(negedge clk);
    check("t3_press_pulses", press_cnt - p0, 1);
    keys = '0;
    wait_valid(1'b0, 51, cyc);
    repeat (20) @(negedge clk);

    // 4: roll 9 -> 12 without a gap
    keys[9] = 1'b1;
    wait_valid(1'b1, 51, cyc);
    check("t4_first_valid", int'(cyc <= 51), 1);
    repeat (30) @(negedge clk);
    p0 = press_cnt; r0 = release_cnt;
    keys = '0;
    keys[12] = 1'b1;
    low = 0; found = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (!key_valid) low++;
      if (key_code == 4'd12) begin
        found = 1;
        break;
      end
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!key_valid) low++;
    end
    check("t4_code_changed", found, 1);
    check("t4_key_code", key_code, 12);
    check("t4_valid_never_low", low, 0);
    check("t4_press_pulses", press_cnt - p0, 1);
    check("t4_no_release", release_cnt - r0, 0);
    keys = '0;
    wait_valid(1'b0, 51, cyc);
    repeat (20) @(negedge clk);

    // 5: two keys (ghost/rollover) ignored, then single key accepted
    p0 = press_cnt;
    keys[1] = 1'b1; keys[10] = 1'b1;
    act = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      act += int'(key_valid) + int'(key_press);
    end
    check("t5_multi_quiet", act, 0);
    check("t5_multi_no_press", press_cnt - p0, 0);
    keys[10] = 1'b0;
    wait_valid(1'b1, 51, cyc);
    check("t5_single_in_time", int'(cyc <= 51), 1);
    check("t5_key_code", key_code, 1);
    keys = '0;
    wait_valid(1'b0, 51, cyc);
    repeat (20) @(negedge clk);

    // 6: reset while a key is held
    keys[5] = 1'b1;
    wait_valid(1'b1, 51, cyc);
    check("t6_first_valid", int'(cyc <= 51), 1);
    repeat (30) @(negedge clk);
    p0 = press_cnt; r0 = release_cnt;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", key_valid, 0);
    check("t6_rst_code", key_code, 0);
    check("t6_rst_row_n", row_n, 4'b1110);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("t6_no_release", release_cnt - r0, 0);
    wait_valid(1'b1, 51, cyc);
    check("t6_repress_in_time", int'(cyc <= 51), 1);
    check("t6_key_code", key_code, 5);
    repeat (10) @(negedge clk);
    check("t6_press_pulses", press_cnt - p0, 1);
    check("t6_release_total", release_cnt - r0, 0);

    check("press_release_exclusive", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
